// File: rtl/neo_pkg.sv
// Shared types and default timing for the smart-LED string driver.
// Timing defaults assume a 100 MHz clock and WS2812/SK6812-class parts.
package neo_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        SEND       = 2'd2,
        LATCH      = 2'd3
    } neo_state_e;

    localparam int GRB_BITS  = 24;
    localparam int GRBW_BITS = 32;

    localparam int DEF_NUM_LEDS     = 30;
    localparam int DEF_CLKS_PER_BIT = 120;
    localparam int DEF_T0H_CLKS     = 40;
    localparam int DEF_T1H_CLKS     = 70;
    localparam int DEF_RESET_CLKS   = 8000;

    function automatic int high_clks(input logic bit_val, input int t0h, input int t1h);
        return bit_val ? t1h : t0h;
    endfunction

endpackage

// File: rtl/neo_string_driver_if.sv
// Pixel stream between the pattern source (master) and the string driver (slave).
interface neo_string_driver_if #(
    parameter int BITS_PER_LED = 32
) ();
    logic [BITS_PER_LED-1:0] pix_data;
    logic                    pix_valid;
    logic                    pix_ready;

    modport master (output pix_data, output pix_valid, input pix_ready);
    modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/neo_bit_encoder.sv
// One encoded bit period: counter plus high-time compare.
// en/bit_val describe the upcoming cycle so the pulse level leaves a flop with no extra latency.
module neo_bit_encoder
    import neo_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int T0H_CLKS     = DEF_T0H_CLKS,
    parameter int T1H_CLKS     = DEF_T1H_CLKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic bit_val,
    output logic level,
    output logic end_of_bit
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          en_r;
    logic          level_r;
    logic          level_s;

    // Next bit-cycle count and the pulse level that goes with it
    always_comb begin
        cnt_s   = '0;
        level_s = 1'b0;
        if (en && en_r && (cnt_r != LAST)) begin
            cnt_s = cnt_r + CW'(1);
        end else begin
            cnt_s = '0;
        end
        if (en) begin
            level_s = (cnt_s < CW'(high_clks(bit_val, T0H_CLKS, T1H_CLKS)));
        end else begin
            level_s = 1'b0;
        end
    end

    // Counter and output level registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_r    <= 1'b0;
            cnt_r   <= '0;
            level_r <= 1'b0;
        end else begin
            en_r    <= en;
            cnt_r   <= cnt_s;
            level_r <= level_s;
        end
    end

    assign level      = level_r;
    assign end_of_bit = en_r & (cnt_r == LAST);

endmodule

// File: rtl/neo_string_driver.sv
// Frame sequencer for a WS2812/SK6812 chain: start/done handshake, one-word
// prefetch buffer, MSB-first shifting, underrun flag and end-of-frame latch gap.
module neo_string_driver
    import neo_pkg::*;
#(
    parameter int NUM_LEDS     = DEF_NUM_LEDS,
    parameter int BITS_PER_LED = GRBW_BITS,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int T0H_CLKS     = DEF_T0H_CLKS,
    parameter int T1H_CLKS     = DEF_T1H_CLKS,
    parameter int RESET_CLKS   = DEF_RESET_CLKS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    neo_string_driver_if.slave pix,
    output logic               dout,
    output logic               busy,
    output logic               done,
    output logic               underrun
);
    localparam int PW = $clog2(NUM_LEDS + 1);
    localparam int IW = $clog2(BITS_PER_LED);
    localparam int LW = $clog2(RESET_CLKS + 1);

    neo_state_e              state_r, state_s;
    logic [BITS_PER_LED-1:0] shift_r, shift_s;
    logic [BITS_PER_LED-1:0] buf_r, buf_s;
    logic                    buf_full_r, buf_full_s;
    logic [PW-1:0]           acc_r, acc_s;
    logic [PW-1:0]           sent_r, sent_s;
    logic [IW-1:0]           bit_idx_r, bit_idx_s;
    logic [LW-1:0]           latch_r, latch_s;
    logic                    busy_r, busy_s;
    logic                    done_r, done_s;
    logic                    underrun_r, underrun_s;
    logic                    ready_r, ready_s;
    logic                    enc_en_s;
    logic                    xfer_s;
    logic                    eob_s;

    assign xfer_s = pix.pix_valid & ready_r;

    // Next-state, datapath and status computation
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        buf_s      = buf_r;
        buf_full_s = buf_full_r;
        acc_s      = acc_r;
        sent_s     = sent_r;
        bit_idx_s  = bit_idx_r;
        latch_s    = latch_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        underrun_s = underrun_r;
        enc_en_s   = 1'b0;
        ready_s    = 1'b0;
        case (state_r)
            IDLE: begin
                // done_r blocks a start arriving in the same cycle as the done pulse
                if (start && !done_r) begin
                    state_s    = WAIT_FIRST;
                    busy_s     = 1'b1;
                    underrun_s = 1'b0;
                    acc_s      = '0;
                    sent_s     = '0;
                    bit_idx_s  = '0;
                    latch_s    = '0;
                    buf_full_s = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_FIRST: begin
                if (xfer_s) begin
                    shift_s   = pix.pix_data;
                    acc_s     = acc_r + PW'(1);
                    bit_idx_s = '0;
                    enc_en_s  = 1'b1;
                    state_s   = SEND;
                end else begin
                    state_s = WAIT_FIRST;
                end
            end
            SEND: begin
                enc_en_s = 1'b1;
                if (eob_s && (bit_idx_r == IW'(BITS_PER_LED - 1))) begin
                    bit_idx_s = '0;
                    if (sent_r == PW'(NUM_LEDS - 1)) begin
                        sent_s   = sent_r + PW'(1);
                        enc_en_s = 1'b0;
                        latch_s  = '0;
                        state_s  = LATCH;
                    end else if (buf_full_r) begin
                        shift_s    = buf_r;
                        buf_full_s = 1'b0;
                        sent_s     = sent_r + PW'(1);
                    end else begin
                        underrun_s = 1'b1;
                        enc_en_s   = 1'b0;
                        latch_s    = '0;
                        state_s    = LATCH;
                    end
                end else if (eob_s) begin
                    shift_s   = {shift_r[BITS_PER_LED-2:0], 1'b0};
                    bit_idx_s = bit_idx_r + IW'(1);
                end else begin
                    shift_s = shift_r;
                end
                // A refill landing on the boundary cycle goes in after the buffer was drained
                if (xfer_s) begin
                    buf_s      = pix.pix_data;
                    buf_full_s = 1'b1;
                    acc_s      = acc_r + PW'(1);
                end else begin
                    buf_s = buf_r;
                end
            end
            LATCH: begin
                if (latch_r == LW'(RESET_CLKS - 1)) begin
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    latch_s = latch_r + LW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
        if (state_s == WAIT_FIRST) begin
            ready_s = 1'b1;
        end else if (state_s == SEND) begin
            ready_s = !buf_full_s && (acc_s < PW'(NUM_LEDS));
        end else begin
            ready_s = 1'b0;
        end
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            shift_r    <= '0;
            buf_r      <= '0;
            buf_full_r <= 1'b0;
            acc_r      <= '0;
            sent_r     <= '0;
            bit_idx_r  <= '0;
            latch_r    <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            underrun_r <= 1'b0;
            ready_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            buf_r      <= buf_s;
            buf_full_r <= buf_full_s;
            acc_r      <= acc_s;
            sent_r     <= sent_s;
            bit_idx_r  <= bit_idx_s;
            latch_r    <= latch_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            underrun_r <= underrun_s;
            ready_r    <= ready_s;
        end
    end

    neo_bit_encoder #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .T0H_CLKS     (T0H_CLKS),
        .T1H_CLKS     (T1H_CLKS)
    ) u_enc (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (enc_en_s),
        .bit_val    (shift_s[BITS_PER_LED-1]),
        .level      (dout),
        .end_of_bit (eob_s)
    );

    assign pix.pix_ready = ready_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign underrun      = underrun_r;

endmodule

// File: tb/tb_neo_string_driver.sv
// Bench for neo_string_driver: 24-bit/2-LED and 32-bit/1-LED instances, dout traces
// compared against a pulse-list model built from the pixel words.
module tb_neo_string_driver;
    localparam int N24 = 2;
    localparam int N32 = 1;
    localparam int C   = 12;
    localparam int T0  = 4;
    localparam int T1  = 7;
    localparam int R   = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start24, start32;
    logic dout24, busy24, done24, und24;
    logic dout32, busy32, done32, und32;

    neo_string_driver_if #(.BITS_PER_LED(24)) if24 ();
    neo_string_driver_if #(.BITS_PER_LED(32)) if32 ();

    neo_string_driver #(.NUM_LEDS(N24), .BITS_PER_LED(24), .CLKS_PER_BIT(C),
                        .T0H_CLKS(T0), .T1H_CLKS(T1), .RESET_CLKS(R)) dut24 (
        .clk(clk), .rst_n(rst_n), .start(start24), .pix(if24.slave),
        .dout(dout24), .busy(busy24), .done(done24), .underrun(und24));

    neo_string_driver #(.NUM_LEDS(N32), .BITS_PER_LED(32), .CLKS_PER_BIT(C),
                        .T0H_CLKS(T0), .T1H_CLKS(T1), .RESET_CLKS(R)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .pix(if32.slave),
        .dout(dout32), .busy(busy32), .done(done32), .underrun(und32));

    int tests = 0;
    int fails = 0;
    int sel = 24;
    logic tr_d[$];
    logic tr_b[$];
    logic tr_dn[$];
    logic tr_u[$];
    logic [31:0] src_q[$];
    logic [31:0] pix_model[$];
    bit src_en = 1'b0;
    bit start_req = 1'b0;
    bit start_on_done = 1'b0;
    int xfer_idx = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] p);
        src_q.push_back(p);
        pix_model.push_back(p);
    endtask

    // One cycle: sample outputs mid-cycle, then drive start and the pixel source.
    task automatic step();
        logic d, b, dn, u, rdy;
        @(negedge clk);
        if (sel == 32) begin
            d = dout32; b = busy32; dn = done32; u = und32; rdy = if32.pix_ready;
        end else begin
            d = dout24; b = busy24; dn = done24; u = und24; rdy = if24.pix_ready;
        end
        tr_d.push_back(d); tr_b.push_back(b); tr_dn.push_back(dn); tr_u.push_back(u);
        if (start_on_done && dn) start_req = 1'b1;
        if (sel == 32) start32 = start_req; else start24 = start_req;
        start_req = 1'b0;
        if (src_en && src_q.size() > 0) begin
            if (sel == 32) begin
                if32.pix_valid = 1'b1; if32.pix_data = src_q[0];
            end else begin
                if24.pix_valid = 1'b1; if24.pix_data = src_q[0][23:0];
            end
            if (rdy) begin
                if (xfer_idx < 0) xfer_idx = tr_d.size() - 1;
                void'(src_q.pop_front());
            end
        end else begin
            if24.pix_valid = 1'b0;
            if32.pix_valid = 1'b0;
        end
    endtask

    // Start a frame, run it to done, and compare the trace with the pulse model.
    task automatic run_frame(input int hold, input int mid_start, input bit sod,
                             input int exp_sent, input bit exp_und);
        int bpl, steps, done_idx, nhigh, m, p, b, ui;
        int rises[$];
        int highs[$];
        bpl = (sel == 32) ? 32 : 24;
        tr_d.delete(); tr_b.delete(); tr_dn.delete(); tr_u.delete();
        xfer_idx = -1;
        src_en = (hold == 0);
        start_on_done = sod;
        start_req = 1'b1;
        step();
        steps = 0;
        done_idx = -1;
        while (done_idx < 0 && steps < 5000) begin
            if (hold > 0 && steps == hold) begin
                nhigh = 0;
                foreach (tr_d[i]) if (tr_d[i] !== 1'b0) nhigh++;
                check("hold_dout_low", nhigh, 0);
                check("hold_busy", tr_b[tr_b.size()-1], 1);
                check("hold_no_underrun", tr_u[tr_u.size()-1], 0);
                src_en = 1'b1;
            end
            if (steps == mid_start) start_req = 1'b1;
            step();
            steps++;
            if (tr_dn[tr_dn.size()-1] === 1'b1) done_idx = tr_dn.size() - 1;
        end
        start_on_done = 1'b0;
        check("done_seen", done_idx >= 0, 1);
        for (int i = 0; i < tr_d.size(); i++) begin
            if (tr_d[i] === 1'b1) begin
                if (i == 0 || tr_d[i-1] !== 1'b1) begin
                    rises.push_back(i);
                    highs.push_back(1);
                end else begin
                    highs[highs.size()-1] = highs[highs.size()-1] + 1;
                end
            end
        end
        check("pulse_count", highs.size(), exp_sent * bpl);
        m = (highs.size() < exp_sent * bpl) ? highs.size() : exp_sent * bpl;
        for (int k = 0; k < m; k++) begin
            p = k / bpl;
            b = bpl - 1 - (k % bpl);
            check("pulse_high", highs[k], pix_model[p][b] ? T1 : T0);
            check("bit_period", rises[k] - rises[0], k * C);
        end
        if (rises.size() > 0 && done_idx >= 0) begin
            check("latency", rises[0], xfer_idx + 1);
            check("frame_len", done_idx - rises[0], exp_sent * bpl * C + R);
            check("busy_at_done", tr_b[done_idx], 0);
            check("busy_before_done", tr_b[done_idx-1], 1);
            check("underrun_at_done", tr_u[done_idx], exp_und);
            if (exp_und) begin
                ui = rises[0] + exp_sent * bpl * C;
                check("underrun_rise", tr_u[ui], 1);
                check("underrun_before", tr_u[ui-1], 0);
            end
        end
        check("busy_at_start", tr_b[0], 0);
        check("busy_after_start", tr_b[1], 1);
        src_q.delete();
        pix_model.delete();
        src_en = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start24 = 1'b0; start32 = 1'b0;
        if24.pix_valid = 1'b0; if24.pix_data = '0;
        if32.pix_valid = 1'b0; if32.pix_data = '0;
        repeat (3) @(negedge clk);
        check("rst_dout", dout24, 0);
        check("rst_busy", busy24, 0);
        check("rst_done", done24, 0);
        check("rst_underrun", und24, 0);
        check("rst_ready", if24.pix_ready, 0);
        check("rst_dout32", dout32, 0);
        rst_n = 1'b1;

        // Directed frame: 8x7, 16x4, 20x4, 4x7 highs
        sel = 24;
        load(32'h00FF0000); load(32'h0000000F);
        run_frame(0, -1, 1'b0, 2, 1'b0);

        // Random frames
        repeat (2) begin
            load($urandom() & 32'h00FFFFFF); load($urandom() & 32'h00FFFFFF);
            run_frame(0, -1, 1'b0, 2, 1'b0);
        end

        // Source stalls 100 cycles after start
        load($urandom() & 32'h00FFFFFF); load($urandom() & 32'h00FFFFFF);
        run_frame(100, -1, 1'b0, 2, 1'b0);

        // Second pixel never arrives -> underrun, then cleared by next start
        load($urandom() & 32'h00FFFFFF);
        run_frame(0, -1, 1'b0, 1, 1'b1);
        load($urandom() & 32'h00FFFFFF); load($urandom() & 32'h00FFFFFF);
        run_frame(0, -1, 1'b0, 2, 1'b0);
        check("underrun_sticky_at_start", tr_u[0], 1);
        check("underrun_cleared", tr_u[1], 0);

        // Start during SEND and on the done cycle are ignored; next cycle start accepted
        load($urandom() & 32'h00FFFFFF); load($urandom() & 32'h00FFFFFF);
        run_frame(0, 50, 1'b1, 2, 1'b0);
        load($urandom() & 32'h00FFFFFF); load($urandom() & 32'h00FFFFFF);
        run_frame(0, -1, 1'b0, 2, 1'b0);

        // Asynchronous reset while dout is high
        load(32'h00FFFFFF); load($urandom() & 32'h00FFFFFF);
        tr_d.delete(); tr_b.delete(); tr_dn.delete(); tr_u.delete();
        src_en = 1'b1;
        start_req = 1'b1;
        step();
        n = 0;
        while (!(n >= 30 && tr_d[tr_d.size()-1] === 1'b1) && n < 200) begin
            step();
            n++;
        end
        check("mid_frame_high", tr_d[tr_d.size()-1], 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dout", dout24, 0);
        check("arst_busy", busy24, 0);
        check("arst_done", done24, 0);
        check("arst_underrun", und24, 0);
        check("arst_ready", if24.pix_ready, 0);
        src_en = 1'b0;
        if24.pix_valid = 1'b0;
        @(posedge clk);
        #1 check("arst_dout_held", dout24, 0);
        @(negedge clk);
        rst_n = 1'b1;
        src_q.delete();
        pix_model.delete();
        load($urandom() & 32'h00FFFFFF); load($urandom() & 32'h00FFFFFF);
        run_frame(0, -1, 1'b0, 2, 1'b0);

        // 32-bit words: bit 31 and bit 0 long, the rest short
        sel = 32;
        load(32'h80000001);
        run_frame(0, -1, 1'b0, 1, 1'b0);
        load($urandom());
        run_frame(0, -1, 1'b0, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
